// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: constants shared by the branch target buffer files
// (FSM state encodings and the sequential fetch step).
package branch_predictor_pkg;

    // Controller states; one bit is enough and keeps the encoding legacy-friendly
    localparam logic [0:0] BP_ST_IDLE  = 1'b0;
    localparam logic [0:0] BP_ST_CLEAR = 1'b1;

    // Byte distance between consecutive fetch PCs (fixed 32-bit instructions)
    localparam int unsigned BP_PC_STEP = 4;

endpackage

// File: rtl/branch_predictor_if.sv
// branch_predictor_if: fetch-lookup and resolve-update signal groups of the BTB.
//
// Handshake: there is no ready. if_en marks a fetch that advances this cycle;
// the lookup answer (pred_taken/pred_target) is combinational on if_pc.
// upd_valid qualifies the whole upd_* group for exactly the cycle it is high;
// the predictor always consumes it, but drops the training write while busy.
// mispredict/redirect_pc are combinational on the upd_* group in the same cycle.
interface branch_predictor_if #(
    parameter int ADDR_W = 32
);
    logic              if_en;
    logic [ADDR_W-1:0] if_pc;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;

    logic              upd_valid;
    logic [ADDR_W-1:0] upd_pc;
    logic              upd_taken;
    logic [ADDR_W-1:0] upd_target;
    logic              upd_pred_taken;
    logic [ADDR_W-1:0] upd_pred_target;
    logic              mispredict;
    logic [ADDR_W-1:0] redirect_pc;

    // Pipeline side: presents fetch PCs and resolved branches
    modport master (
        output if_en, if_pc, upd_valid, upd_pc, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target,
        input  pred_taken, pred_target, mispredict, redirect_pc
    );

    // Predictor side
    modport slave (
        input  if_en, if_pc, upd_valid, upd_pc, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target,
        output pred_taken, pred_target, mispredict, redirect_pc
    );
endinterface

// File: rtl/branch_predictor_sat_cnt.sv
// branch_predictor_sat_cnt: combinational saturating up/down step of a
// direction counter; holds at 0 and at all-ones instead of wrapping.
module branch_predictor_sat_cnt #(
    parameter int CNT_W = 2
) (
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Step toward taken on inc_i, toward not-taken otherwise, clamping at the ends
    always_comb begin
        cnt_o = cnt_i;
        if (inc_i) begin
            if (cnt_i != CNT_MAX) cnt_o = cnt_i + CNT_W'(1);
        end else begin
            if (cnt_i != '0) cnt_o = cnt_i - CNT_W'(1);
        end
    end
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped branch target buffer with per-entry
// saturating direction counters. Zero-latency lookup from the fetch PC,
// training from resolved branches, a one-entry-per-cycle clear walk after
// reset or flush. Optional feature macro: BP_STATS_EN (branch/mispredict counters).
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bp_flush,
    output logic              bp_busy,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispredicts,
    output logic [0:0]        dbg_state_o,
    branch_predictor_if.slave bp
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - 2 - IDX_W;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(2 ** (CNT_W - 1));
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(BP_PC_STEP);

    // Entry storage; no reset so the arrays can map onto RAM
    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [ADDR_W-1:0] target_q [ENTRIES];
    logic [CNT_W-1:0]  cnt_q    [ENTRIES];

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_hit, up_hit;
    logic             pred_taken, mispredict;
    logic             upd_en, clr_en;
    logic [CNT_W-1:0] cnt_step;

    // Fetch enable carries no state here; lookups are purely combinational
    logic unused_if_en;
    assign unused_if_en = bp.if_en;

    assign bp_busy     = (state_q == BP_ST_CLEAR);
    assign dbg_state_o = state_q;

    // Lookup path
    assign lk_idx      = bp.if_pc[IDX_W+1:2];
    assign lk_tag      = bp.if_pc[ADDR_W-1:IDX_W+2];
    assign lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred_taken  = lk_hit && cnt_q[lk_idx][CNT_W-1] && !bp_busy;
    assign bp.pred_taken  = pred_taken;
    assign bp.pred_target = pred_taken ? target_q[lk_idx] : bp.if_pc + PC_STEP;

    // Resolve path: outcome check is valid even while busy
    assign mispredict = bp.upd_valid &&
                        ((bp.upd_taken != bp.upd_pred_taken) ||
                         (bp.upd_taken && (bp.upd_target != bp.upd_pred_target)));
    assign bp.mispredict  = mispredict;
    assign bp.redirect_pc = bp.upd_taken ? bp.upd_target : bp.upd_pc + PC_STEP;

    assign up_idx = bp.upd_pc[IDX_W+1:2];
    assign up_tag = bp.upd_pc[ADDR_W-1:IDX_W+2];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    // Reset beats flush beats training
    assign upd_en = rst_n && !bp_flush && bp.upd_valid && (state_q == BP_ST_IDLE);
    assign clr_en = rst_n && (state_q == BP_ST_CLEAR);

    branch_predictor_sat_cnt #(.CNT_W(CNT_W)) u_sat_cnt (
        .cnt_i (cnt_q[up_idx]),
        .inc_i (bp.upd_taken),
        .cnt_o (cnt_step)
    );

    // Next state: flush (re)starts the walk; the walk ends after the last index
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (bp_flush) begin
            state_d = BP_ST_CLEAR;
            ptr_d   = '0;
        end else if (state_q == BP_ST_CLEAR) begin
            ptr_d = ptr_q + IDX_W'(1);
            if (ptr_q == IDX_W'(ENTRIES - 1)) state_d = BP_ST_IDLE;
        end
    end

    // Controller registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BP_ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Entry writes: clear walk, or train from the resolved branch
    always_ff @(posedge clk) begin
        if (clr_en) begin
            valid_q[ptr_q] <= 1'b0;
        end else if (upd_en) begin
            if (bp.upd_taken) begin
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= bp.upd_target;
                cnt_q[up_idx]    <= up_hit ? cnt_step : CNT_INIT;
            end else if (up_hit) begin
                cnt_q[up_idx] <= cnt_step;
            end
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] stat_br_q, stat_br_d;
    logic [31:0] stat_mp_q, stat_mp_d;

    assign stat_br_d = bp.upd_valid ? stat_br_q + 32'd1 : stat_br_q;
    assign stat_mp_d = mispredict   ? stat_mp_q + 32'd1 : stat_mp_q;

    // Counters run in every state and wrap; only reset clears them
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed + randomized bench for branch_predictor
// (ADDR_W=32, ENTRIES=16, CNT_W=2), checked against a behavioural BTB model.
module tb_branch_predictor;
    import branch_predictor_pkg::*;

    localparam int ENT      = 16;
    localparam int CNT_MAX  = 3;
    localparam int CNT_HALF = 2;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    logic bp_flush;
    logic bp_busy;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
    logic [0:0]  dbg_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    branch_predictor_if #(.ADDR_W(32)) bp_bus ();

    branch_predictor #(.ADDR_W(32), .ENTRIES(ENT), .CNT_W(2)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bp_flush         (bp_flush),
        .bp_busy          (bp_busy),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts),
        .dbg_state_o      (dbg_state),
        .bp               (bp_bus)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Table of what the BTB should remember, addressed by (pc/4) mod ENT.
    bit          m_valid  [ENT];
    logic [31:0] m_tag    [ENT];
    logic [31:0] m_target [ENT];
    int          m_cnt    [ENT];
    int          m_busy;      // busy cycles still to come, including the current one
    logic [31:0] m_br, m_mp;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 32'd4) % 32'(ENT));
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc / 32'(4 * ENT);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    function automatic bit m_pred_taken(input logic [31:0] pc);
        return (m_busy == 0) && m_hit(pc) && (m_cnt[idx_of(pc)] >= CNT_HALF);
    endfunction

    function automatic bit m_mispredict();
        if (!bp_bus.upd_valid) return 1'b0;
        if (bp_bus.upd_taken != bp_bus.upd_pred_taken) return 1'b1;
        return bp_bus.upd_taken && (bp_bus.upd_target != bp_bus.upd_pred_target);
    endfunction

    function automatic logic [31:0] m_redirect();
        return bp_bus.upd_taken ? bp_bus.upd_target : bp_bus.upd_pc + 32'd4;
    endfunction

    task automatic m_invalidate_all();
        for (int i = 0; i < ENT; i++) m_valid[i] = 1'b0;
    endtask

    task automatic m_train();
        int i;
        i = idx_of(bp_bus.upd_pc);
        if (bp_bus.upd_taken) begin
            if (m_hit(bp_bus.upd_pc)) begin
                m_cnt[i] = (m_cnt[i] < CNT_MAX) ? m_cnt[i] + 1 : CNT_MAX;
            end else begin
                m_valid[i] = 1'b1;
                m_tag[i]   = tag_of(bp_bus.upd_pc);
                m_cnt[i]   = CNT_HALF;
            end
            m_target[i] = bp_bus.upd_target;
        end else if (m_hit(bp_bus.upd_pc)) begin
            m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
        end
    endtask

    // What the coming clock edge does to the model, given current inputs
    task automatic m_edge();
        bit mp;
        mp = m_mispredict();
        if (!rst_n) begin
            m_busy = ENT;
            m_br   = '0;
            m_mp   = '0;
            m_invalidate_all();
        end else begin
            if (bp_bus.upd_valid) m_br = m_br + 32'd1;
            if (mp)               m_mp = m_mp + 32'd1;
            if (bp_flush) begin
                m_busy = ENT;
                m_invalidate_all();
            end else if (m_busy > 0) begin
                m_busy--;
            end else if (bp_bus.upd_valid) begin
                m_train();
            end
        end
    endtask

    function automatic logic [31:0] exp_stat_br();
`ifdef BP_STATS_EN
        return m_br;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] exp_stat_mp();
`ifdef BP_STATS_EN
        return m_mp;
`else
        return 32'd0;
`endif
    endfunction

    task automatic check_model(input string tag);
        logic [31:0] pc;
        bit pt;
        pc = bp_bus.if_pc;
        pt = m_pred_taken(pc);
        chk({tag, "_busy"},   32'(bp_busy), 32'(m_busy > 0));
        chk({tag, "_state"},  32'(dbg_state), 32'((m_busy > 0) ? BP_ST_CLEAR : BP_ST_IDLE));
        chk({tag, "_ptaken"}, 32'(bp_bus.pred_taken), 32'(pt));
        chk({tag, "_ptarget"}, bp_bus.pred_target, pt ? m_target[idx_of(pc)] : pc + 32'd4);
        chk({tag, "_mispred"}, 32'(bp_bus.mispredict), 32'(m_mispredict()));
        chk({tag, "_redirect"}, bp_bus.redirect_pc, m_redirect());
        chk({tag, "_stat_br"}, stat_branches, exp_stat_br());
        chk({tag, "_stat_mp"}, stat_mispredicts, exp_stat_mp());
    endtask

    // ---------------- driver tasks ----------------
    task automatic settle();
        #1;
    endtask

    // Check the settled cycle against the model, then take the clock edge
    task automatic cycle(input string tag);
        #1;
        check_model(tag);
        m_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bp_flush                = 1'b0;
        bp_bus.upd_valid        = 1'b0;
        bp_bus.upd_pc           = '0;
        bp_bus.upd_taken        = 1'b0;
        bp_bus.upd_target       = '0;
        bp_bus.upd_pred_taken   = 1'b0;
        bp_bus.upd_pred_target  = '0;
    endtask

    task automatic drive_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                             input logic ptk, input logic [31:0] ptgt);
        bp_bus.upd_valid       = 1'b1;
        bp_bus.upd_pc          = pc;
        bp_bus.upd_taken       = tk;
        bp_bus.upd_target      = tgt;
        bp_bus.upd_pred_taken  = ptk;
        bp_bus.upd_pred_target = ptgt;
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] base;
        case ($urandom_range(0, 3))
            0:       base = 32'h0000_0000;
            1:       base = 32'h0000_0040;
            2:       base = 32'h0000_1000;
            default: base = 32'hFFFF_FFC0;
        endcase
        return base + 32'($urandom_range(0, 15)) * 32'd4;
    endfunction

    // Not-taken/taken training sequence at 0x100 and the prediction expected after each step
    bit t3_tk [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bit t3_ex [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    // Time bound for the whole run
    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        logic [31:0] pc, tgt, exp_rd;
        bit tk, ptk;

        rst_n        = 1'b0;
        bp_bus.if_en = 1'b1;
        bp_bus.if_pc = 32'h40;
        drive_idle();
        @(posedge clk);
        #1;
        m_busy = ENT;
        m_br   = '0;
        m_mp   = '0;
        m_invalidate_all();
        cycle("rst");
        cycle("rst");

        // 1: exactly 16 busy cycles after reset release, never predicting taken
        rst_n = 1'b1;
        for (int i = 0; i < ENT; i++) begin
            settle();
            chk("t1_busy", 32'(bp_busy), 32'd1);
            chk("t1_pred_taken", 32'(bp_bus.pred_taken), 32'd0);
            chk("t1_pred_target", bp_bus.pred_target, 32'h44);
            cycle("t1");
        end
        settle();
        chk("t1_idle", 32'(bp_busy), 32'd0);

        // 2: first taken branch allocates, mispredicts, then predicts next cycle
        bp_bus.if_pc = 32'h100;
        drive_upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
        settle();
        chk("t2_mispredict", 32'(bp_bus.mispredict), 32'd1);
        chk("t2_redirect", bp_bus.redirect_pc, 32'h200);
        chk("t2_miss", 32'(bp_bus.pred_taken), 32'd0);
        cycle("t2");
        drive_idle();
        settle();
        chk("t2_pred_taken", 32'(bp_bus.pred_taken), 32'd1);
        chk("t2_pred_target", bp_bus.pred_target, 32'h200);
        cycle("t2b");

        // 3: counter walks down, holds at 0, walks up, holds at max
        for (int i = 0; i < 8; i++) begin
            drive_upd(32'h100, t3_tk[i], 32'h200, 1'b1, 32'h200);
            settle();
            if (i == 0) begin
                chk("t3_mispredict", 32'(bp_bus.mispredict), 32'd1);
                chk("t3_redirect", bp_bus.redirect_pc, 32'h104);
            end
            cycle("t3");
            drive_idle();
            settle();
            chk($sformatf("t3_pred_step%0d", i), 32'(bp_bus.pred_taken), 32'(t3_ex[i]));
        end

        // 4: alias at the same index replaces the entry
        drive_upd(32'h140, 1'b1, 32'h300, 1'b0, 32'h0);
        cycle("t4");
        drive_idle();
        bp_bus.if_pc = 32'h100;
        settle();
        chk("t4_old_miss", 32'(bp_bus.pred_taken), 32'd0);
        chk("t4_old_target", bp_bus.pred_target, 32'h104);
        bp_bus.if_pc = 32'h140;
        settle();
        chk("t4_new_taken", 32'(bp_bus.pred_taken), 32'd1);
        chk("t4_new_target", bp_bus.pred_target, 32'h300);
        cycle("t4b");

        // 5: same-cycle lookup sees the old entry; flush drops the update and clears
        bp_bus.if_pc = 32'h100;
        drive_upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
        cycle("t5_alloc");
        drive_upd(32'h100, 1'b1, 32'h280, 1'b1, 32'h200);
        settle();
        chk("t5_same_cycle_target", bp_bus.pred_target, 32'h200);
        chk("t5_target_mispredict", 32'(bp_bus.mispredict), 32'd1);
        cycle("t5_same");
        drive_idle();
        settle();
        chk("t5_next_target", bp_bus.pred_target, 32'h280);
        drive_upd(32'h100, 1'b1, 32'h400, 1'b1, 32'h280);
        bp_flush = 1'b1;
        cycle("t5_flush");
        drive_idle();
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("t5_busy_a", 32'(bp_busy), 32'd1);
            cycle("t5_clr");
        end
        bp_flush = 1'b1;
        cycle("t5_reflush");
        bp_flush = 1'b0;
        for (int i = 0; i < ENT; i++) begin
            if (i == ENT - 1) drive_upd(32'h180, 1'b1, 32'h500, 1'b0, 32'h0);
            settle();
            chk("t5_busy_b", 32'(bp_busy), 32'd1);
            chk("t5_busy_pred", 32'(bp_bus.pred_taken), 32'd0);
            cycle("t5_clr2");
        end
        drive_idle();
        settle();
        chk("t5_idle", 32'(bp_busy), 32'd0);
        chk("t5_cleared", 32'(bp_bus.pred_taken), 32'd0);
        bp_bus.if_pc = 32'h180;
        settle();
        chk("t5_busy_upd_dropped", 32'(bp_bus.pred_taken), 32'd0);
        cycle("t5_end");

        // 6: reset mid-update, then 10 updates with 3 mispredicts
        rst_n = 1'b0;
        drive_upd(32'h20, 1'b1, 32'h80, 1'b0, 32'h0);
        cycle("t6_rst");
        cycle("t6_rst");
        rst_n = 1'b1;
        drive_idle();
        for (int i = 0; i < ENT; i++) cycle("t6_clr");
        for (int i = 0; i < 10; i++) begin
            pc = 32'h10 + 32'(i) * 32'h10;
            case (i)
                0, 3:    drive_upd(pc, 1'b1, pc + 32'h40, 1'b1, pc + 32'h40);
                2:       drive_upd(pc, 1'b1, pc + 32'h40, 1'b0, pc + 32'h4);
                5:       drive_upd(pc, 1'b1, pc + 32'h40, 1'b1, pc + 32'h80);
                8:       drive_upd(pc, 1'b0, pc + 32'h40, 1'b1, pc + 32'h40);
                default: drive_upd(pc, 1'b0, pc + 32'h40, 1'b0, pc + 32'h4);
            endcase
            cycle("t6_upd");
        end
        drive_idle();
        settle();
`ifdef BP_STATS_EN
        chk("t6_stat_branches", stat_branches, 32'd10);
        chk("t6_stat_mispredicts", stat_mispredicts, 32'd3);
`else
        chk("t6_stat_branches_off", stat_branches, 32'd0);
        chk("t6_stat_mispredicts_off", stat_mispredicts, 32'd0);
`endif

        // Random traffic: aliasing tags, PC wrap at the top of memory, rare flushes
        for (int n = 0; n < 400; n++) begin
            bp_bus.if_pc = rand_pc();
            bp_flush     = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 9) < 7) begin
                pc  = ($urandom_range(0, 3) == 0) ? bp_bus.if_pc : rand_pc();
                tk  = 1'($urandom_range(0, 1));
                tgt = $urandom() & 32'hFFFF_FFFC;
                ptk = ($urandom_range(0, 1) == 1) ? m_pred_taken(pc) : 1'($urandom_range(0, 1));
                drive_upd(pc, tk, tgt, ptk, ($urandom_range(0, 1) == 1) ? tgt : rand_pc());
                exp_rd = tk ? tgt : pc + 32'd4;
            end else begin
                bp_bus.upd_valid = 1'b0;
                exp_rd = bp_bus.upd_taken ? bp_bus.upd_target : bp_bus.upd_pc + 32'd4;
            end
            exp_q.push_back(exp_rd);
            settle();
            chk("rand_redirect", bp_bus.redirect_pc, exp_q.pop_front());
            cycle("rand");
        end
        drive_idle();
        settle();
        chk("final_stat_branches", stat_branches, exp_stat_br());
        chk("final_stat_mispredicts", stat_mispredicts, exp_stat_mp());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
